mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//   Sequencer for the N-bit shift-add multiplier datapath (A:X:B registers + 9-bit adder).
//   Owns the iteration count; drives clear/load, add, subtract and shift strobes per step.
//   Run starts one multiply; ClearA_LoadB loads B when idle. Sits between switch/button
//   inputs and the register/adder datapath.
// PARAMETERS
//   N_BITS   8   multiplier width = number of add/shift iterations
// PORTS
//   Clk           in   1         clock, all state on rising edge
//   Reset         in   1         asynchronous, active-high; forces IDLE
//   Run           in   1         start request (level); must drop before next multiply
//   ClearA_LoadB  in   1         idle-time request: clear A/X, load B from switches
//   M             in   1         current LSB of B (multiplier bit under test)
//   Clr_Ld        out  1         clear A,X and load B (datapath)
//   ClrAX         out  1         clear A and X only (start of run)
//   Add           out  1         latch A + S into X:A
//   Sub           out  1         latch A - S into X:A (final iteration, two's-complement)
//   Shift         out  1         arithmetic shift X:A:B right by 1
//   Busy          out  1         1 from CLEAR through last SHIFT
//   Done          out  1         1 in HOLD state
//   step_count    out  CW        shifts completed; CW = $clog2(N_BITS+1)
// BEHAVIOUR
//   Reset: state=IDLE, step_count=0, all strobes/Busy/Done=0; applies mid-run, no partial op.
//   States: IDLE -> CLEAR -> {ADD -> SHIFT} x N_BITS -> HOLD -> IDLE. Moore-style strobes
//     except Add/Sub (depend on M) and Clr_Ld (depends on ClearA_LoadB).
//   IDLE:  Run=1 -> CLEAR next cycle. Else Clr_Ld = ClearA_LoadB. Run wins if both high:
//     Clr_Ld=0 that cycle. ClearA_LoadB ignored in every other state.
//   CLEAR: ClrAX=1 one cycle; step_count<=0; -> ADD.
//   ADD:   if M=1: Sub=1 when step_count==N_BITS-1, else Add=1; M=0: no strobe. -> SHIFT.
//          Add and Sub never both 1.
//   SHIFT: Shift=1; step_count<=step_count+1; if step_count==N_BITS-1 -> HOLD else -> ADD.
//   HOLD:  Done=1; step_count held at N_BITS; Run=0 -> IDLE, else stay (no re-trigger
//          while button held). step_count cleared only in CLEAR or Reset.
//   Latency: Run sampled 1 in IDLE at edge t -> ClrAX in t+1, first ADD t+2, last Shift
//     t+2*N_BITS+1, Done from t+2*N_BITS+2 (N_BITS=8: Done at t+18).
//   step_count never exceeds N_BITS; no wrap.
//   Busy = state in {CLEAR, ADD, SHIFT}.
// CONFIGURATION
//   MULT_CTRL_RUN_SYNC_EN defined: Run and ClearA_LoadB each pass a 2-flop synchronizer
//     (reset to 0) before the FSM; all latencies above +2 cycles.
//   Undefined: inputs used directly, latencies as stated.
// STRUCTURE
//   Package mult_ctrl_pkg: state enum typedef (IDLE, CLEAR, ADD, SHIFT, HOLD),
//     default N_BITS constant, CW derivation function.
//   Sub-module mult_step_counter: CW-bit counter with sync clear, increment enable,
//     terminal flag (count==N_BITS-1), async Reset.
// TESTING
//   1 Reset mid-run (assert at 3rd SHIFT) -> next cycle IDLE, step_count=0, all outs 0.
//   2 M=1 every step, N_BITS=8, Run held -> 7 Add, 1 Sub on step 7, 8 Shift, Done at t+18.
//   3 M=0 every step -> zero Add/Sub pulses, 8 Shift pulses, step_count=8 in HOLD.
//   4 Run held 30 cycles after Done -> stays HOLD; release -> IDLE; no second ClrAX.
//   5 IDLE, Run=0, ClearA_LoadB=1 -> Clr_Ld=1; both=1 -> Clr_Ld=0, CLEAR next cycle.
//   6 ClearA_LoadB pulsed during ADD/SHIFT -> Clr_Ld stays 0, sequence unchanged.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier sequencer.
package mult_ctrl_pkg;

  localparam int N_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Counter must reach N_BITS itself, hence the +1.
  function automatic int cw_calc(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Control/strobe bundle between the sequencer (slave) and the switch/datapath side (master).
interface mult_seq_ctrl_if
  import mult_ctrl_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int CW     = cw_calc(N_BITS)
);

  logic          Run;
  logic          ClearA_LoadB;
  logic          M;
  logic          Clr_Ld;
  logic          ClrAX;
  logic          Add;
  logic          Sub;
  logic          Shift;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] step_count;

  modport master (
    output Run, ClearA_LoadB, M,
    input  Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done, step_count
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done, step_count
  );

endinterface

// File: rtl/mult_step_counter.sv
// Iteration counter: sync clear, saturating increment at N_BITS, terminal flag at N_BITS-1.
module mult_step_counter
  import mult_ctrl_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int CW     = cw_calc(N_BITS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          term
);

  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
  localparam logic [CW-1:0] MAX  = CW'(N_BITS);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                      count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != MAX)) count <= count + 1'b1;
  end

  assign term = (count == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the N-bit shift-add multiplier: IDLE -> CLEAR -> {ADD,SHIFT} x N -> HOLD.
// Define MULT_CTRL_RUN_SYNC_EN to put 2-flop synchronizers on Run and ClearA_LoadB.
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  mult_seq_ctrl_if.slave  bus
);

  localparam int CW = cw_calc(N_BITS);

  state_t        state;
  logic          run_s, cla_s;
  logic          term;
  logic [CW-1:0] cnt;
  logic          clr_ax_r, shift_r, busy_r, done_r;

`ifdef MULT_CTRL_RUN_SYNC_EN
  logic [1:0] run_ff, cla_ff;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_ff <= '0;
      cla_ff <= '0;
    end else begin
      run_ff <= {run_ff[0], bus.Run};
      cla_ff <= {cla_ff[0], bus.ClearA_LoadB};
    end
  end

  assign run_s = run_ff[1];
  assign cla_s = cla_ff[1];
`else
  assign run_s = bus.Run;
  assign cla_s = bus.ClearA_LoadB;
`endif

  mult_step_counter #(.N_BITS(N_BITS), .CW(CW)) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (state == CLEAR),
    .inc   (state == SHIFT),
    .count (cnt),
    .term  (term)
  );

  // Moore strobes are registered alongside the state they belong to.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      clr_ax_r <= 1'b0;
      shift_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      clr_ax_r <= 1'b0;
      shift_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      case (state)
        IDLE: if (run_s) begin
          state    <= CLEAR;
          clr_ax_r <= 1'b1;
          busy_r   <= 1'b1;
        end
        CLEAR: begin
          state  <= ADD;
          busy_r <= 1'b1;
        end
        ADD: begin
          state   <= SHIFT;
          shift_r <= 1'b1;
          busy_r  <= 1'b1;
        end
        SHIFT: if (term) begin
          state  <= HOLD;
          done_r <= 1'b1;
        end else begin
          state  <= ADD;
          busy_r <= 1'b1;
        end
        // Wait for Run to drop so a held button cannot retrigger.
        HOLD: if (!run_s) state  <= IDLE;
              else        done_r <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ClrAX      = clr_ax_r;
  assign bus.Shift      = shift_r;
  assign bus.Busy       = busy_r;
  assign bus.Done       = done_r;
  assign bus.step_count = cnt;

  // Last iteration subtracts: the multiplier MSB carries negative weight.
  assign bus.Add    = (state == ADD) && bus.M && !term;
  assign bus.Sub    = (state == ADD) && bus.M &&  term;
  assign bus.Clr_Ld = (state == IDLE) && !run_s && cla_s;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed + randomized bench for mult_seq_ctrl against a cycle-schedule reference model.
module tb_mult_seq_ctrl;
  import mult_ctrl_pkg::*;

  localparam int NB = 8;
  localparam int CW = cw_calc(NB);

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mult_seq_ctrl_if #(.N_BITS(NB)) bus ();

  mult_seq_ctrl #(.N_BITS(NB)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_sc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit ca, input bit ad, input bit sb,
                          input bit sh, input bit bz, input bit dn, input int sc, input bit cl);
    chk({tag, ".ClrAX"},      32'(bus.ClrAX),      32'(ca));
    chk({tag, ".Add"},        32'(bus.Add),        32'(ad));
    chk({tag, ".Sub"},        32'(bus.Sub),        32'(sb));
    chk({tag, ".Shift"},      32'(bus.Shift),      32'(sh));
    chk({tag, ".Busy"},       32'(bus.Busy),       32'(bz));
    chk({tag, ".Done"},       32'(bus.Done),       32'(dn));
    chk({tag, ".step_count"}, 32'(bus.step_count), 32'(sc));
    chk({tag, ".Clr_Ld"},     32'(bus.Clr_Ld),     32'(cl));
  endtask

  // One full multiply. Entered ~1 time unit after an edge with the DUT idle.
  // Period k = k-th clock period after the edge that samples Run: CLEAR at k=1,
  // ADD step s at k=2+2s, SHIFT step s at k=3+2s, HOLD from k=2*NB+2.
  task automatic do_run(input logic [NB-1:0] mb, input int hold, input bit noise, input string nm);
    int adds, subs, shifts, s;
    bit ea, es;
    adds = 0; subs = 0; shifts = 0;
    bus.Run = 1'b1;
    bus.ClearA_LoadB = noise;
    bus.M = 1'($urandom_range(0, 1));
    #1 chk({nm, ".arb.Clr_Ld"}, 32'(bus.Clr_Ld), 32'd0);
    @(posedge Clk);
    for (int k = 1; k <= 2*NB + 1; k++) begin
      #1;
      s = (k >= 2) ? (k - 2) / 2 : 0;
      bus.M = (k % 2 == 0) ? mb[s] : 1'($urandom_range(0, 1));
      bus.ClearA_LoadB = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      ea = (k % 2 == 0) && mb[s] && (s <  NB - 1);
      es = (k % 2 == 0) && mb[s] && (s == NB - 1);
      chk_outs($sformatf("%s.k%0d", nm, k), k == 1, ea, es, (k % 2 == 1) && (k >= 3),
               1'b1, 1'b0, (k == 1) ? model_sc : s, 1'b0);
      adds   += int'(bus.Add);
      subs   += int'(bus.Sub);
      shifts += int'(bus.Shift);
      @(posedge Clk);
    end
    model_sc = NB;
    for (int h = 0; h <= hold; h++) begin
      #1;
      bus.ClearA_LoadB = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk_outs($sformatf("%s.hold%0d", nm, h), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NB, 1'b0);
      if (h == hold) bus.Run = 1'b0;
      @(posedge Clk);
    end
    bus.ClearA_LoadB = 1'b0;
    #1 chk_outs({nm, ".idle0"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NB, 1'b0);
    @(posedge Clk);
    #1 chk_outs({nm, ".idle1"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NB, 1'b0);
    chk({nm, ".n_add"},   32'(adds),   32'($countones(mb[NB-2:0])));
    chk({nm, ".n_sub"},   32'(subs),   32'(mb[NB-1]));
    chk({nm, ".n_shift"}, 32'(shifts), 32'(NB));
  endtask

  initial begin
    logic [NB-1:0] mb;
    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.M = 1'b0;
    #12;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    Reset = 1'b0;
    @(posedge Clk);
    #1 chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Idle-time load request, alone.
    bus.ClearA_LoadB = 1'b1;
    #1 chk("cla.Clr_Ld", 32'(bus.Clr_Ld), 32'd1);
    @(posedge Clk);
    #1 chk_outs("cla.stay", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    bus.ClearA_LoadB = 1'b0;
    #1 chk("cla.off", 32'(bus.Clr_Ld), 32'd0);
    @(posedge Clk);
    #1;

    do_run({NB{1'b1}}, 0, 1'b0, "ones");
    do_run({NB{1'b0}}, 0, 1'b0, "zeros");
    do_run(NB'($urandom), 30, 1'b0, "hold30");
    do_run(NB'($urandom), 2, 1'b1, "both_noise");
    for (int r = 0; r < 6; r++) begin
      mb = NB'($urandom);
      do_run(mb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    // Reset asserted during the third SHIFT.
    bus.Run = 1'b1;
    @(posedge Clk);
    repeat (6) @(posedge Clk);
    #1 chk("rst.pre.Shift", 32'(bus.Shift), 32'd1);
    chk("rst.pre.step_count", 32'(bus.step_count), 32'd2);
    Reset = 1'b1;
    bus.Run = 1'b0;
    #1;
    model_sc = 0;
    chk_outs("rst.now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge Clk);
    #1 chk_outs("rst.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    Reset = 1'b0;
    @(posedge Clk);
    #1 chk_outs("rst.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_run(NB'($urandom), 1, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
